// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the two-master bus arbiter.
package bus_arb_pkg;

  // Bus owner / winner encoding; NONE means the bus is idle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    M0   = 2'd1,
    M1   = 2'd2
  } owner_e;

  localparam int unsigned ADDR_W_DEFAULT    = 32;
  localparam int unsigned DATA_W_DEFAULT    = 32;
  localparam int unsigned MAX_BURST_DEFAULT = 4;

  // Beat counter width; enough for MAX_BURST up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/bus_arb_sel.sv
// Combinational winner selection for the two-master arbiter.
module bus_arb_sel
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic             i_m0_req,
  input  logic             i_m1_req,
  input  logic [1:0]       i_owner,
  input  logic [1:0]       i_last,
  input  logic [CNT_W-1:0] i_beat_cnt,
  output logic [1:0]       o_winner
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

  owner_e w_owner;
  owner_e w_last;
  owner_e w_win;
  logic   w_burst_open;

  assign w_owner      = owner_e'(i_owner);
  assign w_last       = owner_e'(i_last);
  // The current owner may continue while its burst has room left.
  assign w_burst_open = (i_beat_cnt < MaxCnt);

  // Pick the winner: owner continuation first, then single request, then fairness on contention.
  always_comb begin
    w_win = NONE;
    if (w_owner == M0 && i_m0_req && (w_burst_open || !i_m1_req)) begin
      w_win = M0;
    end else if (w_owner == M1 && i_m1_req && (w_burst_open || !i_m0_req)) begin
      w_win = M1;
    end else if (i_m0_req && i_m1_req) begin
      // Contention with an expired burst hands over; from idle, alternate against last.
      unique case (w_owner)
        M0:      w_win = M1;
        M1:      w_win = M0;
        default: w_win = (w_last == M0) ? M1 : M0;
      endcase
    end else if (i_m0_req) begin
      w_win = M0;
    end else if (i_m1_req) begin
      w_win = M1;
    end
  end

  assign o_winner = w_win;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master single-beat bus arbiter (CPU data port m0, DMA m1) in front of a shared RAM.
// Zero-latency grant, bounded bursts, one-cycle read return per master.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m0_gnt,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_rvalid,
  output logic              o_m1_gnt,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_rvalid,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

  owner_e             r_owner;
  owner_e             r_last;
  logic [CNT_W-1:0]   r_beat_cnt;
  owner_e             w_owner_d;
  owner_e             w_last_d;
  logic [CNT_W-1:0]   w_beat_cnt_d;
  logic [1:0]         w_sel_winner;
  owner_e             w_winner;
  logic [DATA_W-1:0]  r_m0_rdata;
  logic [DATA_W-1:0]  r_m1_rdata;
  logic               r_m0_rvalid;
  logic               r_m1_rvalid;

  bus_arb_sel #(
    .MAX_BURST (MAX_BURST)
  ) u_sel (
    .i_m0_req   (i_m0_req),
    .i_m1_req   (i_m1_req),
    .i_owner    (r_owner),
    .i_last     (r_last),
    .i_beat_cnt (r_beat_cnt),
    .o_winner   (w_sel_winner)
  );

  // Reset suppresses any grant in the same cycle.
  assign w_winner = i_reset ? NONE : owner_e'(w_sel_winner);

  // Arbitration state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_owner    <= NONE;
      r_last     <= M1;
      r_beat_cnt <= '0;
    end else begin
      r_owner    <= w_owner_d;
      r_last     <= w_last_d;
      r_beat_cnt <= w_beat_cnt_d;
    end
  end

  // Next arbitration state: extend the owner's burst or start a fresh count.
  always_comb begin
    w_owner_d    = r_owner;
    w_last_d     = r_last;
    w_beat_cnt_d = r_beat_cnt;
    if (w_winner == NONE) begin
      w_owner_d    = NONE;
      w_beat_cnt_d = '0;
    end else begin
      w_owner_d = w_winner;
      w_last_d  = w_winner;
      if (w_winner == r_owner) begin
        w_beat_cnt_d = (r_beat_cnt >= MaxCnt) ? MaxCnt : r_beat_cnt + 4'd1;
      end else begin
        w_beat_cnt_d = 4'd1;
      end
    end
  end

  // Grants and bus mux driven by the winner; idle bus is all zero.
  always_comb begin
    o_m0_gnt    = 1'b0;
    o_m1_gnt    = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;
    unique case (w_winner)
      M0: begin
        o_m0_gnt    = 1'b1;
        o_bus_we    = i_m0_we;
        o_bus_addr  = i_m0_addr;
        o_bus_wdata = i_m0_wdata;
      end
      M1: begin
        o_m1_gnt    = 1'b1;
        o_bus_we    = i_m1_we;
        o_bus_addr  = i_m1_addr;
        o_bus_wdata = i_m1_wdata;
      end
      default: ;
    endcase
  end

  // Read return: capture RAM data on a granted read, pulse rvalid the next cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= o_m0_gnt & ~i_m0_we;
      r_m1_rvalid <= o_m1_gnt & ~i_m1_we;
      if (o_m0_gnt && !i_m0_we) r_m0_rdata <= i_bus_rdata;
      if (o_m1_gnt && !i_m1_we) r_m1_rdata <= i_bus_rdata;
    end
  end

  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;
  assign o_m0_rvalid = r_m0_rvalid;
  assign o_m1_rvalid = r_m1_rvalid;

endmodule
